mem_req_buffer: RTL and testbench
=================================

Name: mem_req_buffer

Overview:
- Sits between memsys_top's main-memory port and memory_model.
- Queues outgoing memory requests in program order in a FIFO of depth_p entries.
- Acknowledges writes upstream as soon as they are accepted (posted writes).
- Serves a read directly from the youngest queued write to the same block when one exists; otherwise the read goes to memory behind all earlier writes.
- Keeps at most one downstream transaction outstanding and at most one upstream read pending.

Parameters:
width_words_p, 4, words per memory transfer; block-aligned compare ignores addr[$clog2(width_words_p*4)-1:0]
depth_p, 4, request FIFO entries; power of 2, >=2

Ports:
clk  in  1  clock
nreset  in  1  reset, synchronous, active-high
up_valid_i  in  1  request valid from memsys_top
up_ready_o  out  1  buffer can accept a request
up_we_i  in  1  1=write, 0=read
up_addr_i  in  32  byte address
up_wdata_i  in  32*width_words_p  write data
up_valid_o  out  1  response/ack valid, single-cycle pulse
up_data_o  out  32*width_words_p  read data (0 on write ack)
dn_valid_o  out  1  request valid to memory
dn_ready_i  in  1  memory ready
dn_we_o  out  1  write enable
dn_addr_o  out  32  address
dn_wdata_o  out  32*width_words_p  write data
dn_valid_i  in  1  memory completion pulse (reads and writes)
dn_data_i  in  32*width_words_p  read data

Behaviour:
- Reset:
  - FIFO empty; rd_pending=0; dn_busy=0.
  - up_valid_o=0, up_data_o=0, dn_valid_o=0.
  - up_ready_o=0 while nreset is asserted.
- Ready and accept:
  - up_ready_o = ~full & ~rd_pending & ~nreset.
  - Accept = up_valid_i & up_ready_o. At most one accept per cycle.
- Write accept:
  - Push {1, addr, wdata} into the FIFO.
  - Next cycle: up_valid_o=1 and up_data_o=0.
- Read accept, forwarding hit:
  - Hit = any valid FIFO entry with we=1 and block-aligned addr equal to the read's.
  - Select the youngest matching entry.
  - Next cycle: up_valid_o=1 and up_data_o=that entry's wdata. The read is not enqueued.
- Read accept, miss:
  - Push {0, addr, x} into the FIFO and set rd_pending.
- Downstream issue:
  - dn_valid_o = ~empty & ~dn_busy. dn_* fields driven from the FIFO head.
  - On dn_valid_o & dn_ready_i: pop the head, set dn_busy, record whether the issued entry is a read.
- Downstream completion:
  - On dn_valid_i: clear dn_busy.
  - If the outstanding entry is a read: next cycle up_valid_o=1, up_data_o=dn_data_i registered; clear rd_pending in that same cycle.
  - Write completions are not forwarded upstream; they were already acked.
- Latency:
  - Write ack: 1 cycle after accept.
  - Forwarded read: 1 cycle after accept.
  - Memory read: 1 cycle after dn_valid_i.
- Response collisions cannot occur: rd_pending blocks new accepts while a memory read is outstanding.
- Ordering:
  - An in-flight popped write is not a forwarding source. A read to the same block is enqueued and therefore issued only after that write completes.
  - Memory observes requests in accept order.
- Boundaries:
  - Simultaneous push and pop is allowed; count is unchanged.
  - Full: no accept (ready=0).
  - Empty: dn_valid_o=0.
  - Pointers are $clog2(depth_p)+1 bits and wrap modulo 2*depth_p for the full/empty distinction.
- Errors:
  - dn_valid_i while dn_busy=0 is ignored.
  - Assertion in simulation: dn_valid_i with dn_busy=0 is an error.
- Reset mid-operation discards queued and in-flight requests. No response is issued for them.

Optional Feature:
- Macro: MEM_REQ_BUFFER_COALESCE_EN.
- Defined:
  - A write whose block address matches the youngest FIFO entry, and that entry is a write, overwrites that entry's wdata instead of pushing. It is still acked next cycle.
  - Count is unchanged. The head entry qualifies only if it has not yet been popped.
  - The full condition still blocks acceptance.
- Undefined: every accepted write allocates a new entry.

Test Plan:
- Reset 10 cycles, then idle -> up_ready_o=1, dn_valid_o=0, up_valid_o=0.
- Write A=0x40 data D1, memory delay 5 -> up_valid_o one cycle later with data 0; dn write issued with addr 0x40, data D1; no upstream pulse on the memory completion.
- Writes 0x40=D1 then 0x40=D2, then read 0x48 while both are queued (dn_ready_i=0) -> read served next cycle with D2; no downstream read issued.
- Read 0x80 with empty queue, memory returns R -> up_ready_o=0 until the response; up_valid_o with R exactly 1 cycle after dn_valid_i.
- Hold dn_ready_i=0 and issue depth_p=4 writes -> up_ready_o=0 after the 4th; release dn_ready_i -> writes drain in order 1..4 and ready returns after the first pop.
- COALESCE_EN: two writes to 0x100 with dn_ready_i=0 -> count=1, single downstream write carrying the second data. Without the macro -> count=2, two downstream writes.

Source files
------------

// File: rtl/mem_req_buffer.sv
// Posted-write request buffer between memsys_top and memory_model, with
// store-to-load forwarding. Define MEM_REQ_BUFFER_COALESCE_EN to merge same-block writes.
module mem_req_buffer #(
    parameter int width_words_p = 4,
    parameter int depth_p       = 4
) (
    input  logic                        clk,
    input  logic                        nreset,
    input  logic                        up_valid_i,
    output logic                        up_ready_o,
    input  logic                        up_we_i,
    input  logic [31:0]                 up_addr_i,
    input  logic [32*width_words_p-1:0] up_wdata_i,
    output logic                        up_valid_o,
    output logic [32*width_words_p-1:0] up_data_o,
    output logic                        dn_valid_o,
    input  logic                        dn_ready_i,
    output logic                        dn_we_o,
    output logic [31:0]                 dn_addr_o,
    output logic [32*width_words_p-1:0] dn_wdata_o,
    input  logic                        dn_valid_i,
    input  logic [32*width_words_p-1:0] dn_data_i
);

    localparam int data_w_lp = 32 * width_words_p;
    localparam int off_w_lp  = $clog2(width_words_p * 4);
    localparam int idx_w_lp  = $clog2(depth_p);
    localparam int ptr_w_lp  = idx_w_lp + 1;

    function automatic logic same_block(input logic [31:0] a, input logic [31:0] b);
        return (a[31:off_w_lp] == b[31:off_w_lp]);
    endfunction

    logic [depth_p-1:0]   ent_we_q, ent_we_d;
    logic [31:0]          ent_addr_q  [depth_p];
    logic [31:0]          ent_addr_d  [depth_p];
    logic [data_w_lp-1:0] ent_wdata_q [depth_p];
    logic [data_w_lp-1:0] ent_wdata_d [depth_p];
    logic [ptr_w_lp-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ptr_w_lp-1:0]  rd_ptr_q, rd_ptr_d;
    logic                 rd_pending_q, rd_pending_d;
    logic                 dn_busy_q, dn_busy_d;
    logic                 dn_is_rd_q, dn_is_rd_d;
    logic                 up_valid_q, up_valid_d;
    logic [data_w_lp-1:0] up_data_q, up_data_d;

    logic [ptr_w_lp-1:0]  count_s;
    logic                 empty_s;
    logic                 full_s;
    logic [idx_w_lp-1:0]  rd_idx_s;
    logic [idx_w_lp-1:0]  wr_idx_s;
    logic                 accept_s;
    logic                 issue_s;
    logic                 push_s;
    logic                 coal_s;
    logic                 rsp_rd_s;
    logic [idx_w_lp-1:0]  slot_s [depth_p];
    logic [depth_p-1:0]   fwd_match_s;
    logic                 fwd_hit_s;
    logic [data_w_lp-1:0] fwd_data_s;

    assign count_s  = wr_ptr_q - rd_ptr_q;
    assign empty_s  = (wr_ptr_q == rd_ptr_q);
    assign full_s   = (count_s == ptr_w_lp'(depth_p));
    assign rd_idx_s = rd_ptr_q[idx_w_lp-1:0];
    assign wr_idx_s = wr_ptr_q[idx_w_lp-1:0];

    assign up_ready_o = ~full_s & ~rd_pending_q & ~nreset;
    assign accept_s   = up_valid_i & up_ready_o;
    assign dn_valid_o = ~empty_s & ~dn_busy_q;
    assign issue_s    = dn_valid_o & dn_ready_i;
    assign rsp_rd_s   = dn_valid_i & dn_busy_q & dn_is_rd_q;

    assign dn_we_o    = ent_we_q[rd_idx_s];
    assign dn_addr_o  = ent_addr_q[rd_idx_s];
    assign dn_wdata_o = ent_wdata_q[rd_idx_s];
    assign up_valid_o = up_valid_q;
    assign up_data_o  = up_data_q;

    // Forwarding search: slot i is the i-th oldest queued entry; the youngest match wins.
    always_comb begin
        fwd_data_s = {data_w_lp{1'b0}};
        for (int i = 0; i < depth_p; i++) begin
            slot_s[i]      = idx_w_lp'(rd_ptr_q + ptr_w_lp'(i));
            fwd_match_s[i] = (ptr_w_lp'(i) < count_s) & ent_we_q[slot_s[i]]
                             & same_block(ent_addr_q[slot_s[i]], up_addr_i);
            fwd_data_s     = fwd_match_s[i] ? ent_wdata_q[slot_s[i]] : fwd_data_s;
        end
        fwd_hit_s = |fwd_match_s;
    end

`ifdef MEM_REQ_BUFFER_COALESCE_EN
    logic [idx_w_lp-1:0] tail_idx_s;

    // Merge into the youngest entry unless it is the head leaving this very cycle.
    always_comb begin
        tail_idx_s = idx_w_lp'(wr_ptr_q - ptr_w_lp'(1));
        coal_s     = accept_s & up_we_i & ~empty_s & ent_we_q[tail_idx_s]
                     & same_block(ent_addr_q[tail_idx_s], up_addr_i)
                     & ~(issue_s & (count_s == ptr_w_lp'(1)));
    end
`else
    assign coal_s = 1'b0;
`endif

    assign push_s = accept_s & (up_we_i ? ~coal_s : ~fwd_hit_s);

    // Next-state logic for queue storage, pointers, downstream tracking and responses.
    always_comb begin
        ent_we_d    = ent_we_q;
        ent_addr_d  = ent_addr_q;
        ent_wdata_d = ent_wdata_q;

        if (push_s) begin
            ent_we_d[wr_idx_s]    = up_we_i;
            ent_addr_d[wr_idx_s]  = up_addr_i;
            ent_wdata_d[wr_idx_s] = up_wdata_i;
            wr_ptr_d              = wr_ptr_q + ptr_w_lp'(1);
        end
`ifdef MEM_REQ_BUFFER_COALESCE_EN
        else if (coal_s) begin
            ent_wdata_d[tail_idx_s] = up_wdata_i;
            wr_ptr_d                = wr_ptr_q;
        end
`endif
        else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (issue_s) begin
            rd_ptr_d   = rd_ptr_q + ptr_w_lp'(1);
            dn_busy_d  = 1'b1;
            dn_is_rd_d = ~ent_we_q[rd_idx_s];
        end else if (dn_valid_i & dn_busy_q) begin
            rd_ptr_d   = rd_ptr_q;
            dn_busy_d  = 1'b0;
            dn_is_rd_d = dn_is_rd_q;
        end else begin
            rd_ptr_d   = rd_ptr_q;
            dn_busy_d  = dn_busy_q;
            dn_is_rd_d = dn_is_rd_q;
        end

        // rd_pending blocks accepts, so a memory read response never meets an ack.
        if (rsp_rd_s) begin
            up_valid_d   = 1'b1;
            up_data_d    = dn_data_i;
            rd_pending_d = 1'b0;
        end else if (accept_s & (up_we_i | fwd_hit_s)) begin
            up_valid_d   = 1'b1;
            up_data_d    = up_we_i ? {data_w_lp{1'b0}} : fwd_data_s;
            rd_pending_d = rd_pending_q;
        end else if (accept_s) begin
            up_valid_d   = 1'b0;
            up_data_d    = {data_w_lp{1'b0}};
            rd_pending_d = 1'b1;
        end else begin
            up_valid_d   = 1'b0;
            up_data_d    = {data_w_lp{1'b0}};
            rd_pending_d = rd_pending_q;
        end
    end

    // State registers; reset discards queued and in-flight requests.
    always_ff @(posedge clk) begin
        if (nreset) begin
            ent_we_q     <= {depth_p{1'b0}};
            for (int i = 0; i < depth_p; i++) begin
                ent_addr_q[i]  <= 32'h0000_0000;
                ent_wdata_q[i] <= {data_w_lp{1'b0}};
            end
            wr_ptr_q     <= {ptr_w_lp{1'b0}};
            rd_ptr_q     <= {ptr_w_lp{1'b0}};
            rd_pending_q <= 1'b0;
            dn_busy_q    <= 1'b0;
            dn_is_rd_q   <= 1'b0;
            up_valid_q   <= 1'b0;
            up_data_q    <= {data_w_lp{1'b0}};
        end else begin
            ent_we_q     <= ent_we_d;
            ent_addr_q   <= ent_addr_d;
            ent_wdata_q  <= ent_wdata_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_pending_q <= rd_pending_d;
            dn_busy_q    <= dn_busy_d;
            dn_is_rd_q   <= dn_is_rd_d;
            up_valid_q   <= up_valid_d;
            up_data_q    <= up_data_d;
        end
    end

    mem_req_buffer_chk u_chk (
        .clk        (clk),
        .nreset     (nreset),
        .dn_valid_i (dn_valid_i),
        .dn_busy    (dn_busy_q)
    );

endmodule

// Protocol checker: memory must not complete a transaction that was never issued.
module mem_req_buffer_chk (
    input logic clk,
    input logic nreset,
    input logic dn_valid_i,
    input logic dn_busy
);

    property p_no_orphan_completion;
        @(posedge clk) disable iff (nreset) dn_valid_i |-> dn_busy;
    endproperty

    a_no_orphan_completion: assert property (p_no_orphan_completion);

endmodule

// File: tb/tb_mem_req_buffer.sv
// Directed scoreboard bench for mem_req_buffer: upstream responses and downstream
// requests are predicted at stimulus time and checked as the DUT produces them.
module tb_mem_req_buffer;

    localparam int WW = 4;
    localparam int DW = 32 * WW;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
        bit            from_mem;
    } up_exp_t;

    typedef struct {
        logic          we;
        logic [31:0]   addr;
        logic [DW-1:0] data;
    } dn_exp_t;

    logic          clk = 1'b0;
    logic          nreset;
    logic          up_valid_i;
    logic          up_ready_o;
    logic          up_we_i;
    logic [31:0]   up_addr_i;
    logic [DW-1:0] up_wdata_i;
    logic          up_valid_o;
    logic [DW-1:0] up_data_o;
    logic          dn_valid_o;
    logic          dn_ready_i;
    logic          dn_we_o;
    logic [31:0]   dn_addr_o;
    logic [DW-1:0] dn_wdata_o;
    logic          dn_valid_i;
    logic [DW-1:0] dn_data_i;

    up_exp_t up_q[$];
    dn_exp_t dn_q[$];
    int      vectors      = 0;
    int      miscompares  = 0;
    int      cyc          = 0;
    int      mem_delay    = 5;
    int      last_rsp_cyc = 0;
    bit      rsp_busy     = 1'b0;

    mem_req_buffer #(.width_words_p(WW), .depth_p(4)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .up_valid_i (up_valid_i),
        .up_ready_o (up_ready_o),
        .up_we_i    (up_we_i),
        .up_addr_i  (up_addr_i),
        .up_wdata_i (up_wdata_i),
        .up_valid_o (up_valid_o),
        .up_data_o  (up_data_o),
        .dn_valid_o (dn_valid_o),
        .dn_ready_i (dn_ready_i),
        .dn_we_o    (dn_we_o),
        .dn_addr_o  (dn_addr_o),
        .dn_wdata_o (dn_wdata_o),
        .dn_valid_i (dn_valid_i),
        .dn_data_i  (dn_data_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mem_rdata(input logic [31:0] a);
        return {WW{a ^ 32'hC0DE_0000}};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_dn(input logic we, input logic [31:0] a, input logic [DW-1:0] d);
        dn_exp_t e;
        e.we = we;
        e.addr = a;
        e.data = d;
        dn_q.push_back(e);
    endtask

    // Drive one request once ready; the upstream response is predicted at drive time.
    task automatic send(input logic we, input logic [31:0] a, input logic [DW-1:0] d,
                        input bit from_mem, input logic [DW-1:0] exp_data);
        int n = 0;
        up_exp_t e;
        while (!up_ready_o && n < 200) begin
            step();
            n++;
        end
        chkb("send_ready", up_ready_o, 1'b1);
        up_valid_i = 1'b1;
        up_we_i    = we;
        up_addr_i  = a;
        up_wdata_i = d;
        e.data     = exp_data;
        e.cyc      = cyc + 1;
        e.from_mem = from_mem;
        up_q.push_back(e);
        step();
        up_valid_i = 1'b0;
        up_we_i    = 1'b0;
        up_addr_i  = 32'h0;
        up_wdata_i = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((up_q.size() != 0 || dn_q.size() != 0 || rsp_busy || dn_valid_o) && n < 300) begin
            step();
            n++;
        end
        chkb("drain_timeout", (n < 300), 1'b1);
        repeat (3) step();
    endtask

    // Upstream monitor: every pulse must match the oldest prediction, data and cycle.
    always @(negedge clk) begin
        up_exp_t e;
        if (!nreset && up_valid_o) begin
            chkb("up_expected_pulse", (up_q.size() != 0), 1'b1);
            if (up_q.size() != 0) begin
                e = up_q.pop_front();
                chk("up_data", up_data_o, e.data);
                chki("up_cycle", cyc, e.from_mem ? last_rsp_cyc + 1 : e.cyc);
            end
        end
    end

    // Downstream monitor: issued requests must appear in predicted order.
    always @(negedge clk) begin
        dn_exp_t e;
        if (!nreset && dn_valid_o && dn_ready_i) begin
            chkb("dn_expected_req", (dn_q.size() != 0), 1'b1);
            if (dn_q.size() != 0) begin
                e = dn_q.pop_front();
                chkb("dn_we", dn_we_o, e.we);
                chk("dn_addr", {{(DW-32){1'b0}}, dn_addr_o}, {{(DW-32){1'b0}}, e.addr});
                if (e.we) chk("dn_wdata", dn_wdata_o, e.data);
            end
        end
    end

    // Memory responder: completes each accepted request mem_delay cycles later.
    initial begin
        logic        rwe;
        logic [31:0] ra;
        dn_valid_i = 1'b0;
        dn_data_i  = '0;
        forever begin
            @(negedge clk);
            if (!nreset && dn_valid_o && dn_ready_i) begin
                rwe      = dn_we_o;
                ra       = dn_addr_o;
                rsp_busy = 1'b1;
                @(posedge clk);
                repeat (mem_delay) @(posedge clk);
                #1;
                dn_valid_i   = 1'b1;
                dn_data_i    = rwe ? '0 : mem_rdata(ra);
                last_rsp_cyc = cyc;
                @(posedge clk);
                #1;
                dn_valid_i = 1'b0;
                dn_data_i  = '0;
                rsp_busy   = 1'b0;
            end
        end
    end

    initial begin
        logic [DW-1:0] d1, d2, d3, e1, e2;
        logic [DW-1:0] wd;
        d1 = {WW{32'h1111_0001}};
        d2 = {WW{32'h2222_0002}};
        d3 = {WW{32'h3333_0003}};
        e1 = {WW{32'hE1E1_0100}};
        e2 = {WW{32'hE2E2_0100}};

        nreset     = 1'b1;
        up_valid_i = 1'b0;
        up_we_i    = 1'b0;
        up_addr_i  = 32'h0;
        up_wdata_i = '0;
        dn_ready_i = 1'b0;
        repeat (10) step();
        chkb("rst_up_ready", up_ready_o, 1'b0);
        chkb("rst_up_valid", up_valid_o, 1'b0);
        chkb("rst_dn_valid", dn_valid_o, 1'b0);
        chk("rst_up_data", up_data_o, '0);

        nreset = 1'b0;
        step();
        chkb("idle_up_ready", up_ready_o, 1'b1);
        chkb("idle_dn_valid", dn_valid_o, 1'b0);
        chkb("idle_up_valid", up_valid_o, 1'b0);

        // Posted write: ack next cycle, memory completion stays silent upstream.
        dn_ready_i = 1'b1;
        mem_delay  = 5;
        push_dn(1'b1, 32'h40, d1);
        send(1'b1, 32'h40, d1, 1'b0, '0);
        wait_idle();

        // Forward the youngest of two queued same-block writes.
        dn_ready_i = 1'b0;
`ifdef MEM_REQ_BUFFER_COALESCE_EN
        push_dn(1'b1, 32'h40, d2);
`else
        push_dn(1'b1, 32'h40, d1);
        push_dn(1'b1, 32'h40, d2);
`endif
        send(1'b1, 32'h40, d1, 1'b0, '0);
        send(1'b1, 32'h40, d2, 1'b0, '0);
        send(1'b0, 32'h48, '0, 1'b0, d2);
        step();
        chkb("held_dn_valid", dn_valid_o, 1'b1);
        chkb("held_dn_we", dn_we_o, 1'b1);
        dn_ready_i = 1'b1;
        wait_idle();

        // Memory read: ready stays low until the response.
        push_dn(1'b0, 32'h80, '0);
        send(1'b0, 32'h80, '0, 1'b1, mem_rdata(32'h80));
        chkb("rd_pend_ready_0", up_ready_o, 1'b0);
        repeat (3) step();
        chkb("rd_pend_ready_1", up_ready_o, 1'b0);
        wait_idle();
        chkb("rd_done_ready", up_ready_o, 1'b1);

        // A write already issued downstream must not forward; the read goes behind it.
        mem_delay = 4;
        push_dn(1'b1, 32'h300, d3);
        push_dn(1'b0, 32'h300, '0);
        send(1'b1, 32'h300, d3, 1'b0, '0);
        step();
        send(1'b0, 32'h300, '0, 1'b1, mem_rdata(32'h300));
        wait_idle();

        // Fill the queue, then drain in order.
        dn_ready_i = 1'b0;
        mem_delay  = 2;
        for (int i = 0; i < 4; i++) begin
            wd = {WW{32'hA000_0000 + 32'(i)}};
            push_dn(1'b1, 32'h200 + 32'(16 * i), wd);
            send(1'b1, 32'h200 + 32'(16 * i), wd, 1'b0, '0);
        end
        chkb("full_ready", up_ready_o, 1'b0);
        dn_ready_i = 1'b1;
        step();
        chkb("ready_after_pop", up_ready_o, 1'b1);
        wait_idle();

        // Two writes to one block while downstream is stalled.
        dn_ready_i = 1'b0;
`ifdef MEM_REQ_BUFFER_COALESCE_EN
        push_dn(1'b1, 32'h100, e2);
`else
        push_dn(1'b1, 32'h100, e1);
        push_dn(1'b1, 32'h100, e2);
`endif
        send(1'b1, 32'h100, e1, 1'b0, '0);
        send(1'b1, 32'h100, e2, 1'b0, '0);
        step();
        dn_ready_i = 1'b1;
        wait_idle();

        chki("up_q_left", up_q.size(), 0);
        chki("dn_q_left", dn_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
